// File: rtl/firebird7_in_gate2_ijtag_seq_pkg.sv
// Shared encodings and defaults for the gate2 IJTAG scan sequencer.
package firebird7_in_gate2_ijtag_seq_pkg;

  localparam int unsigned MAX_LEN_DEF = 64;
  localparam int unsigned RST_CYC_DEF = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_UPDATE  = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;
  localparam logic [2:0] ST_NRST    = 3'd5;

  localparam logic [1:0] OP_SCAN      = 2'd0;
  localparam logic [1:0] OP_NET_RESET = 2'd1;

endpackage

// File: rtl/firebird7_in_gate2_ijtag_seq_shreg.sv
// Shift-in data register, shift-out sample register and bit counter for one scan command.
module firebird7_in_gate2_ijtag_seq_shreg #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] data_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               so,
  output logic               si_next_c,
  output logic               len_nz_c,
  output logic               last_c,
  output logic [MAX_LEN-1:0] rsp_data
);

  logic [MAX_LEN-1:0] shreg_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_clamp_c;
  logic [MAX_LEN-1:0] so_bit_c;

  // Clamp requested length to the register size; widen net_so to a one-hot source bit.
  always_comb begin
    len_clamp_c = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
    so_bit_c    = {{(MAX_LEN-1){1'b0}}, so};
  end

  // Load on accept; each shift cycle samples net_so into bit cnt and advances the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rsp_data <= '0;
    end else if (load) begin
      shreg_q  <= data_in;
      len_q    <= len_clamp_c;
      cnt_q    <= '0;
      rsp_data <= '0;
    end else if (shift) begin
      shreg_q  <= shreg_q >> 1;
      cnt_q    <= cnt_q + LEN_W'(1);
      rsp_data <= rsp_data | (so_bit_c << cnt_q);
    end
  end

  // Bit that will sit at the register head after this edge, plus length/terminal-count flags.
  always_comb begin
    si_next_c = shreg_q[0];
    if (load) begin
      si_next_c = data_in[0];
    end else if (shift) begin
      si_next_c = shreg_q[1];
    end
    len_nz_c = (len_q != '0);
    last_c   = (cnt_q == (len_q - LEN_W'(1)));
  end

endmodule

// File: rtl/firebird7_in_gate2_ijtag_scan_sequencer.sv
// Runs capture/shift/update or network-reset sequences on one IJTAG network from a cmd/rsp port.
module firebird7_in_gate2_ijtag_scan_sequencer
  import firebird7_in_gate2_ijtag_seq_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned RST_CYC = RST_CYC_DEF
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_capture,
  input  logic               cmd_update,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               net_reset_n,
  output logic               net_sel,
  output logic               net_ce,
  output logic               net_se,
  output logic               net_ue,
  output logic               net_si,
  input  logic               net_so,
  output logic               busy
);

  localparam int unsigned RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [RST_W-1:0] rst_cnt_q;
  logic [RST_W-1:0] rst_cnt_d;
  logic             upd_q;
  logic             upd_d;
  logic             accept_c;
  logic             load_c;
  logic             shift_c;
  logic             len_in_nz_c;
  logic             si_next_c;
  logic             len_nz_c;
  logic             last_c;
  logic             sel_d;

  firebird7_in_gate2_ijtag_seq_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clk       (ijtag_tck),
    .reset     (ijtag_reset),
    .load      (load_c),
    .shift     (shift_c),
    .data_in   (cmd_data),
    .len_in    (cmd_len),
    .so        (net_so),
    .si_next_c (si_next_c),
    .len_nz_c  (len_nz_c),
    .last_c    (last_c),
    .rsp_data  (rsp_data)
  );

  // Next-state logic; phases chain without a deselect gap inside a scan.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    upd_d       = upd_q;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    accept_c    = cmd_valid && cmd_ready;
    len_in_nz_c = (cmd_len != '0);

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          load_c    = 1'b1;
          upd_d     = cmd_update;
          rst_cnt_d = '0;
          case (cmd_op)
            OP_SCAN: begin
              if (cmd_capture)      state_d = ST_CAPTURE;
              else if (len_in_nz_c) state_d = ST_SHIFT;
              else if (cmd_update)  state_d = ST_UPDATE;
              else                  state_d = ST_RESP;
            end
            OP_NET_RESET: state_d = ST_NRST;
            default:      state_d = ST_RESP;
          endcase
        end
      end
      ST_CAPTURE: begin
        if (len_nz_c)   state_d = ST_SHIFT;
        else if (upd_q) state_d = ST_UPDATE;
        else            state_d = ST_RESP;
      end
      ST_SHIFT: begin
        shift_c = 1'b1;
        if (last_c) state_d = upd_q ? ST_UPDATE : ST_RESP;
      end
      ST_UPDATE: state_d = ST_RESP;
      ST_NRST: begin
        if (rst_cnt_q == RST_W'(RST_CYC - 1)) state_d = ST_RESP;
        else rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    sel_d = (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) || (state_d == ST_UPDATE);
  end

  // State register; every output is registered off the next state so it lines up with its phase.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      upd_q       <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      net_reset_n <= 1'b0;
      net_sel     <= 1'b0;
      net_ce      <= 1'b0;
      net_se      <= 1'b0;
      net_ue      <= 1'b0;
      net_si      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      upd_q       <= upd_d;
      cmd_ready   <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      rsp_valid   <= (state_d == ST_RESP);
      net_reset_n <= (state_d != ST_NRST);
      net_sel     <= sel_d;
      net_ce      <= (state_d == ST_CAPTURE);
      net_se      <= (state_d == ST_SHIFT);
      net_ue      <= (state_d == ST_UPDATE);
      net_si      <= (state_d == ST_SHIFT) && si_next_c;
    end
  end

endmodule
